// File: rtl/mux_dec_pkg.sv
// Shared mode encoding and one-hot helper for the scan/select multiplexer.
package mux_dec_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // Widest channel count the one-hot helper can represent.
    localparam int unsigned MAX_CH = 64;

    // One-hot of sel over nch channels; all zero when disabled or out of range.
    function automatic logic [MAX_CH-1:0] f_onehot(
        input int unsigned sel,
        input logic        en,
        input int unsigned nch
    );
        logic [MAX_CH-1:0] y;
        y = '0;
        if (en && (sel < nch) && (sel < MAX_CH)) begin
            y = MAX_CH'(1) << sel;
        end
        return y;
    endfunction

endpackage

// File: rtl/sel_decoder.sv
// Combinational binary-to-one-hot decoder with enable and out-of-range flag.
module sel_decoder
    import mux_dec_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned SEL_W = $clog2(NCH)
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [NCH-1:0]   y,
    output logic             oor
);

    // Decode the select; flag codes that name no existing channel.
    always_comb begin
        y   = NCH'(f_onehot(32'(sel), en, NCH));
        oor = (32'(sel) >= NCH);
    end

endmodule

// File: rtl/mux_dec_scan_sel.sv
// N-channel multiplexer with manual select or auto-scan with programmable dwell.
// Pointer, dwell counter, decode and data are all registered on the same edge.
module mux_dec_scan_sel
    import mux_dec_pkg::*;
#(
    parameter int unsigned NCH     = 4,
    parameter int unsigned DW      = 1,
    parameter int unsigned SEL_W   = $clog2(NCH),
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel_in,
    input  logic               load,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NCH*DW-1:0]  din,
    output logic [NCH-1:0]     dec_y,
    output logic [DW-1:0]      dout,
    output logic               dout_valid,
    output logic [SEL_W-1:0]   sel_cur,
    output logic               wrap,
    output logic               err
);

    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_nxt;
    logic [SEL_W-1:0]   nxt;
    logic [SEL_W-1:0]   step_sel;
    logic               last_ch;
    logic               in_range;
    logic               valid_nxt;
    logic               wrap_nxt;
    logic               err_nxt;
    logic [NCH-1:0]     dec_nxt;
    logic               dec_oor;
    logic [DW-1:0]      dout_nxt;

    // Next pointer, dwell count and status pulses from mode, load and dwell.
    always_comb begin
        in_range  = ({1'b0, sel_in} < (SEL_W+1)'(NCH));
        last_ch   = (sel_cur == SEL_W'(NCH - 1));
        step_sel  = last_ch ? '0 : sel_cur + 1'b1;
        nxt       = sel_cur;
        cnt_nxt   = cnt;
        valid_nxt = 1'b0;
        wrap_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (en) begin
            if (mode == MODE_MANUAL) begin
                // Holding cnt at 0 makes a later switch to SCAN start a fresh dwell.
                cnt_nxt = '0;
                if (in_range) begin
                    nxt       = sel_in;
                    valid_nxt = 1'b1;
                end else begin
                    err_nxt = 1'b1;
                end
            end else begin
                valid_nxt = 1'b1;
                if (load && in_range) begin
                    nxt     = sel_in;
                    cnt_nxt = '0;
                end else begin
                    // A rejected load still flags err but must not disturb stepping.
                    err_nxt = load;
                    if (cnt == dwell) begin
                        nxt      = step_sel;
                        cnt_nxt  = '0;
                        wrap_nxt = last_ch;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
        end
    end

    sel_decoder #(
        .NCH   (NCH),
        .SEL_W (SEL_W)
    ) u_dec (
        .sel (nxt),
        .en  (valid_nxt),
        .y   (dec_nxt),
        .oor (dec_oor)
    );

    // Data path picks the channel the pointer is about to hold.
    always_comb begin
        dout_nxt = '0;
        if (valid_nxt && !dec_oor) begin
            dout_nxt = din[nxt*DW +: DW];
        end
    end

    // State and output registers, all advancing together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_cur    <= '0;
            cnt        <= '0;
            dec_y      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            wrap       <= 1'b0;
            err        <= 1'b0;
        end else begin
            sel_cur    <= nxt;
            cnt        <= cnt_nxt;
            dec_y      <= dec_nxt;
            dout       <= dout_nxt;
            dout_valid <= valid_nxt & ~dec_oor;
            wrap       <= wrap_nxt;
            err        <= err_nxt;
        end
    end

endmodule

// File: tb/tb_mux_dec_scan_sel.sv
// Scoreboard bench: stimulus queues expected outputs, a negedge monitor compares.
module tb_mux_dec_scan_sel;

    typedef struct {
        string      name;
        logic [3:0] dec;
        logic       dout;
        logic       vld;
        logic [1:0] sel;
        logic       wrap;
        logic       err;
    } exp_t;

    logic clk;
    logic rst_n;

    // Four-channel instance
    logic       en4, mode4, load4;
    logic [1:0] sel4;
    logic [7:0] dwell4;
    logic [3:0] din4;
    logic [3:0] dec4;
    logic       dout4, vld4, wrap4, err4;
    logic [1:0] selc4;

    // Three-channel instance
    logic       en3, mode3, load3;
    logic [1:0] sel3;
    logic [7:0] dwell3;
    logic [2:0] din3;
    logic [2:0] dec3;
    logic       dout3, vld3, wrap3, err3;
    logic [1:0] selc3;

    exp_t q4[$];
    exp_t q3[$];
    int   vectors = 0;
    int   miscompares = 0;

    mux_dec_scan_sel #(.NCH(4), .DW(1), .DWELL_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .mode(mode4), .sel_in(sel4),
        .load(load4), .dwell(dwell4), .din(din4), .dec_y(dec4), .dout(dout4),
        .dout_valid(vld4), .sel_cur(selc4), .wrap(wrap4), .err(err4)
    );

    mux_dec_scan_sel #(.NCH(3), .DW(1), .DWELL_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3), .sel_in(sel3),
        .load(load3), .dwell(dwell3), .din(din3), .dec_y(dec3), .dout(dout3),
        .dout_valid(vld3), .sel_cur(selc3), .wrap(wrap3), .err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input string nm, input logic [3:0] d, input logic o,
                                input logic v, input logic [1:0] s, input logic w,
                                input logic e);
        exp_t x;
        x.name = nm; x.dec = d; x.dout = o; x.vld = v; x.sel = s; x.wrap = w; x.err = e;
        return x;
    endfunction

    task automatic check(input exp_t e, input logic [3:0] a_dec, input logic a_dout,
                         input logic a_vld, input logic [1:0] a_sel, input logic a_wrap,
                         input logic a_err);
        vectors++;
        if ({a_dec, a_dout, a_vld, a_sel, a_wrap, a_err} !==
            {e.dec, e.dout, e.vld, e.sel, e.wrap, e.err}) begin
            miscompares++;
            $display("FAIL %s: got dec=%b dout=%b vld=%b sel=%0d wrap=%b err=%b, want dec=%b dout=%b vld=%b sel=%0d wrap=%b err=%b",
                     e.name, a_dec, a_dout, a_vld, a_sel, a_wrap, a_err,
                     e.dec, e.dout, e.vld, e.sel, e.wrap, e.err);
        end
    endtask

    // Monitor: compare every queued expectation against the settled outputs.
    always @(negedge clk) begin
        while (q4.size() > 0) begin
            exp_t e;
            e = q4.pop_front();
            check(e, dec4, dout4, vld4, selc4, wrap4, err4);
        end
        while (q3.size() > 0) begin
            exp_t e;
            e = q3.pop_front();
            check(e, {1'b0, dec3}, dout3, vld3, selc3, wrap3, err3);
        end
    end

    task automatic cyc4(input logic en, input logic md, input logic [1:0] s,
                        input logic ld, input logic [7:0] dw, input exp_t e);
        en4 = en; mode4 = md; sel4 = s; load4 = ld; dwell4 = dw;
        @(posedge clk);
        q4.push_back(e);
        #1;
    endtask

    task automatic cyc3(input logic en, input logic md, input logic [1:0] s,
                        input logic ld, input logic [7:0] dw, input exp_t e);
        en3 = en; mode3 = md; sel3 = s; load3 = ld; dwell3 = dw;
        @(posedge clk);
        q3.push_back(e);
        #1;
    endtask

    // Asynchronous reset asserted between edges, held across one edge.
    task automatic do_reset(input bit on3);
        exp_t z;
        z = mk("reset", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        if (on3) q3.push_back(z); else q4.push_back(z);
        @(posedge clk);
        if (on3) q3.push_back(z); else q4.push_back(z);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want run to complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        en4 = 0; mode4 = 0; sel4 = 0; load4 = 0; dwell4 = 0; din4 = 0;
        en3 = 0; mode3 = 0; sel3 = 0; load3 = 0; dwell3 = 0; din3 = 0;
        #1;
        q4.push_back(mk("por4", 4'b0000, 0, 0, 2'd0, 0, 0));
        q3.push_back(mk("por3", 4'b0000, 0, 0, 2'd0, 0, 0));
        @(posedge clk);
        q4.push_back(mk("por4_edge", 4'b0000, 0, 0, 2'd0, 0, 0));
        q3.push_back(mk("por3_edge", 4'b0000, 0, 0, 2'd0, 0, 0));
        #1;
        rst_n = 1'b1;

        // Manual select over din = 0101
        din4 = 4'b0101;
        cyc4(1, 0, 2'd0, 0, 8'd0, mk("man_sel0", 4'b0001, 1, 1, 2'd0, 0, 0));
        cyc4(1, 0, 2'd1, 0, 8'd0, mk("man_sel1", 4'b0010, 0, 1, 2'd1, 0, 0));
        cyc4(1, 0, 2'd2, 0, 8'd0, mk("man_sel2", 4'b0100, 1, 1, 2'd2, 0, 0));
        cyc4(1, 0, 2'd3, 0, 8'd0, mk("man_sel3", 4'b1000, 0, 1, 2'd3, 0, 0));

        // Scan dwell=2 from reset: three cycles per channel, wrap every 12
        do_reset(0);
        din4 = 4'b1011;
        for (int k = 1; k <= 26; k++) begin
            int s;
            s = (k / 3) % 4;
            cyc4(1, 1, 2'd0, 0, 8'd2,
                 mk("scan_dw2", 4'(1) << s, din4[s], 1, 2'(s), (k % 12) == 0, 0));
        end

        // Three channels, dwell=0: 1,2,0,... never 3, wrap every third cycle
        do_reset(1);
        din3 = 3'b110;
        for (int k = 1; k <= 9; k++) begin
            int s;
            s = k % 3;
            cyc3(1, 1, 2'd0, 0, 8'd0,
                 mk("scan3_dw0", 4'(1) << s, din3[s], 1, 2'(s), (k % 3) == 0, 0));
        end

        // Out-of-range manual select and load on three channels
        cyc3(1, 0, 2'd1, 0, 8'd0, mk("man3_sel1",  4'b0010, 1, 1, 2'd1, 0, 0));
        cyc3(1, 0, 2'd3, 0, 8'd0, mk("man3_oor",   4'b0000, 0, 0, 2'd1, 0, 1));
        cyc3(1, 1, 2'd3, 1, 8'd0, mk("load3_oor",  4'b0100, 1, 1, 2'd2, 0, 1));
        cyc3(1, 1, 2'd0, 0, 8'd0, mk("scan3_wrap", 4'b0001, 0, 1, 2'd0, 1, 0));

        // Load colliding with dwell expiry, then release and resume
        do_reset(0);
        din4 = 4'b1011;
        cyc4(1, 1, 2'd2, 1, 8'd3, mk("load2",       4'b0100, 0, 1, 2'd2, 0, 0));
        cyc4(1, 1, 2'd2, 0, 8'd3, mk("dwell_cnt1",  4'b0100, 0, 1, 2'd2, 0, 0));
        cyc4(1, 1, 2'd2, 0, 8'd3, mk("dwell_cnt2",  4'b0100, 0, 1, 2'd2, 0, 0));
        cyc4(1, 1, 2'd2, 0, 8'd3, mk("dwell_cnt3",  4'b0100, 0, 1, 2'd2, 0, 0));
        cyc4(1, 1, 2'd1, 1, 8'd3, mk("load_at_dw",  4'b0010, 1, 1, 2'd1, 0, 0));
        cyc4(1, 1, 2'd1, 0, 8'd3, mk("post_load",   4'b0010, 1, 1, 2'd1, 0, 0));
        for (int k = 0; k < 5; k++) begin
            cyc4(0, 1, 2'd0, 1, 8'd3, mk("en_off",  4'b0000, 0, 0, 2'd1, 0, 0));
        end
        cyc4(1, 1, 2'd0, 0, 8'd3, mk("resume_c2",   4'b0010, 1, 1, 2'd1, 0, 0));
        cyc4(1, 1, 2'd0, 0, 8'd3, mk("resume_c3",   4'b0010, 1, 1, 2'd1, 0, 0));
        cyc4(1, 1, 2'd0, 0, 8'd3, mk("resume_step", 4'b0100, 0, 1, 2'd2, 0, 0));

        // Reset in the middle of a scan, then restart from channel 0
        cyc4(1, 1, 2'd0, 0, 8'd0, mk("pre_rst",     4'b1000, 1, 1, 2'd3, 0, 0));
        do_reset(0);
        cyc4(1, 1, 2'd0, 0, 8'd1, mk("rst_ch0",     4'b0001, 1, 1, 2'd0, 0, 0));
        cyc4(1, 1, 2'd0, 0, 8'd1, mk("rst_step",    4'b0010, 1, 1, 2'd1, 0, 0));

        repeat (2) @(negedge clk);
        #1;
        if (q4.size() != 0 || q3.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", q4.size() + q3.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
